// File: rtl/cpu_pkg.sv
// Shared register write-back types: data/address widths, the queued request
// record and the address-to-enable decoder used by the write-back sequencer.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // An index outside 0..NREG-1 decodes to all zeros, i.e. a dropped write.
  function automatic logic [NREG-1:0] onehot_dec(input logic [ADDR_W-1:0] addr);
    logic [NREG-1:0] vec;
    for (int i = 0; i < NREG; i++) begin
      vec[i] = (addr == ADDR_W'(i));
    end
    return vec;
  endfunction

endpackage

// File: rtl/reg_wb_fifo.sv
// Synchronous FIFO of write-back requests. Besides the head it exposes every
// entry in age order (index 0 = oldest) with a valid bit, for hazard lookup.
module reg_wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  clr_i,
  input  wb_req_t               wr_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DEPTH-1:0]      age_valid_o,
  output wb_req_t [DEPTH-1:0]   age_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  wb_req_t [DEPTH-1:0] mem_q;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers and entry storage.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !clr_i) begin
        mem_q[wr_ptr_q] <= wr_i;
      end
    end
  end

  // Rotate storage into age order relative to the read pointer.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_o[k]       = mem_q[rd_ptr_q + PW'(k)];
      age_valid_o[k] = (CW'(k) < count_q);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/reg_wb_queue.sv
// Register write-back sequencer: queues writes and retires one per cycle as a
// one-hot enable plus shared data. Define REG_WB_QUEUE_FWD_EN for lookup_data.
module reg_wb_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  output logic [NREG-1:0]        reg_en,
  output logic [DATA_W-1:0]      reg_data,
  input  logic [ADDR_W-1:0]      lookup_addr,
  output logic                   lookup_hit,
`ifdef REG_WB_QUEUE_FWD_EN
  output logic [DATA_W-1:0]      lookup_data,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_req_t             wr_s;
  wb_req_t [DEPTH-1:0] age_s;
  logic [DEPTH-1:0]    age_valid_s;
  logic [DEPTH-1:0]    q_match_s;
  logic [CW-1:0]       count_s;
  logic                push_s;
  logic                pop_s;
  logic                en_hit_s;
  logic [NREG-1:0]     reg_en_q, reg_en_d;
  logic [DATA_W-1:0]   reg_data_q, reg_data_d;

  assign wr_s.addr = in_addr;
  assign wr_s.data = in_data;

  // Full is judged on the current count only; a same-cycle pop does not make room.
  assign in_ready = (count_s < CW'(DEPTH)) && !flush;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = (count_s != '0) && !flush;

  reg_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .reset      (reset),
    .push_i     (push_s),
    .pop_i      (pop_s),
    .clr_i      (flush),
    .wr_i       (wr_s),
    .count_o    (count_s),
    .age_valid_o(age_valid_s),
    .age_o      (age_s)
  );

  // Retire stage next-state: data holds when nothing retires.
  always_comb begin
    if (pop_s) begin
      reg_en_d   = onehot_dec(age_s[0].addr);
      reg_data_d = age_s[0].data;
    end else begin
      reg_en_d   = '0;
      reg_data_d = reg_data_q;
    end
  end

  // Retire stage registers driving the register bank.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      reg_en_q   <= '0;
      reg_data_q <= '0;
    end else begin
      reg_en_q   <= reg_en_d;
      reg_data_q <= reg_data_d;
    end
  end

  // Per-entry address match against the decode query.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      q_match_s[k] = age_valid_s[k] && (age_s[k].addr == lookup_addr);
    end
  end

  assign en_hit_s   = |(reg_en_q & onehot_dec(lookup_addr));
  assign lookup_hit = (|q_match_s) || en_hit_s;

`ifdef REG_WB_QUEUE_FWD_EN
  // Oldest-to-youngest walk so the youngest queued match overrides.
  always_comb begin
    lookup_data = en_hit_s ? reg_data_q : '0;
    for (int k = 0; k < DEPTH; k++) begin
      lookup_data = q_match_s[k] ? age_s[k].data : lookup_data;
    end
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^age_s;
`endif

  assign reg_en   = reg_en_q;
  assign reg_data = reg_data_q;
  assign count    = count_s;
  assign busy     = (count_s != '0) || (reg_en_q != '0);

endmodule

// File: tb/tb_reg_wb_queue.sv
// Scoreboard bench for reg_wb_queue: a queue-level reference model predicts
// retires and combinational outputs; a monitor checks each retire as it appears.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_addr = 3'd0;
  logic [15:0] in_data = 16'h0;
  logic        flush = 1'b0;
  logic [7:0]  reg_en;
  logic [15:0] reg_data;
  logic [2:0]  lookup_addr = 3'd0;
  logic        lookup_hit;
`ifdef REG_WB_QUEUE_FWD_EN
  logic [15:0] lookup_data;
`endif
  logic [2:0]  count;
  logic        busy;

  always #5 CLK = ~CLK;

  reg_wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .flush      (flush),
    .reg_en     (reg_en),
    .reg_data   (reg_data),
    .lookup_addr(lookup_addr),
    .lookup_hit (lookup_hit),
`ifdef REG_WB_QUEUE_FWD_EN
    .lookup_data(lookup_data),
`endif
    .count      (count),
    .busy       (busy)
  );

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } req_t;

  typedef struct {
    logic [7:0]  en;
    logic [15:0] d;
    int          cyc;
  } ret_t;

  req_t        pend[$];
  ret_t        exp_q[$];
  logic        en_v = 1'b0;
  logic [2:0]  en_a = 3'd0;
  logic [15:0] en_d = 16'h0;
  int          edge_n = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h (edge %0d)", nm, got, want, edge_n);
    end
  endtask

  // Monitor: every retire the DUT shows, or the model says is due, is matched in order.
  always @(posedge CLK) begin
    ret_t r;
    #1;
    if (reg_en != 8'h00 || (exp_q.size() > 0 && exp_q[0].cyc == edge_n)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_retire got reg_en=%0h expected none (edge %0d)", reg_en, edge_n);
      end else begin
        r = exp_q.pop_front();
        chk("reg_en", {24'h0, reg_en}, {24'h0, r.en});
        chk("reg_data", {16'h0, reg_data}, {16'h0, r.d});
        chk("retire_cycle", edge_n, r.cyc);
      end
    end
  end

  // One clock of stimulus: drive, check combinational predictions, then advance the model.
  task automatic step(input logic rst, input logic v, input logic [2:0] a,
                      input logic [15:0] d, input logic fl, input logic [2:0] la);
    logic        rdy_e;
    logic        hit_e;
    logic [15:0] fwd_e;
    req_t        m;
    ret_t        r;
    @(negedge CLK);
    reset = rst; in_valid = v; in_addr = a; in_data = d; flush = fl; lookup_addr = la;
    #1;
    if (!rst) begin
      pend.delete();
      en_v = 1'b0;
    end
    rdy_e = (pend.size() < DEPTH) && !fl;
    hit_e = en_v && (en_a == la);
    fwd_e = hit_e ? en_d : 16'h0;
    foreach (pend[i]) begin
      if (pend[i].a == la) begin
        hit_e = 1'b1;
        fwd_e = pend[i].d;
      end
    end
    chk("in_ready", {31'h0, in_ready}, {31'h0, rdy_e});
    chk("count", {29'h0, count}, pend.size());
    chk("busy", {31'h0, busy}, {31'h0, (pend.size() != 0) || en_v});
    chk("lookup_hit", {31'h0, lookup_hit}, {31'h0, hit_e});
`ifdef REG_WB_QUEUE_FWD_EN
    chk("lookup_data", {16'h0, lookup_data}, {16'h0, fwd_e});
`endif
    @(posedge CLK);
    edge_n++;
    if (!rst || fl) begin
      pend.delete();
      en_v = 1'b0;
    end else begin
      if (pend.size() > 0) begin
        m = pend.pop_front();
        en_v = 1'b1; en_a = m.a; en_d = m.d;
        r.en = 8'h01 << m.a; r.d = m.d; r.cyc = edge_n;
        exp_q.push_back(r);
      end else begin
        en_v = 1'b0;
      end
      if (v && rdy_e) begin
        m.a = a; m.d = d;
        pend.push_back(m);
      end
    end
  endtask

  task automatic idle(input int n, input logic [2:0] la);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, la);
  endtask

  initial begin
    #1 reset = 1'b0;
    step(1'b0, 1'b1, 3'd5, 16'h5555, 1'b0, 3'd5);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    chk("reset_reg_en", {24'h0, reg_en}, 32'h0);
    chk("reset_reg_data", {16'h0, reg_data}, 32'h0);

    // Single write: enable one cycle after the push edge, then idle.
    step(1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd3);
    idle(3, 3'd3);

    // Back-to-back pushes drain in order.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 3'(i), 16'h0100 + 16'(i), 1'b0, 3'(i));
    idle(3, 3'd5);

    // Same address twice: hazard visible until the second write leaves reg_en.
    step(1'b1, 1'b1, 3'd2, 16'hAAAA, 1'b0, 3'd2);
    step(1'b1, 1'b1, 3'd2, 16'hBBBB, 1'b0, 3'd2);
    idle(4, 3'd2);

    // Flush with a request present: refused, queue empties, write on reg_en completes.
    step(1'b1, 1'b1, 3'd5, 16'h5A5A, 1'b0, 3'd6);
    step(1'b1, 1'b1, 3'd6, 16'h6B6B, 1'b0, 3'd6);
    step(1'b1, 1'b1, 3'd7, 16'hDEAD, 1'b1, 3'd7);
    idle(3, 3'd6);

    // Asynchronous reset between edges while a write is on reg_en and one is queued.
    step(1'b1, 1'b1, 3'd1, 16'h1111, 1'b0, 3'd4);
    step(1'b1, 1'b1, 3'd4, 16'h4444, 1'b0, 3'd4);
    #2 reset = 1'b0;
    #1;
    chk("async_reg_en", {24'h0, reg_en}, 32'h0);
    chk("async_count", {29'h0, count}, 32'h0);
    chk("async_busy", {31'h0, busy}, 32'h0);
    chk("async_reg_data", {16'h0, reg_data}, 32'h0);
    pend.delete();
    en_v = 1'b0;
    exp_q.delete();
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd4);
    idle(2, 3'd4);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           16'($urandom_range(0, 65535)), ($urandom_range(0, 15) == 0),
           3'($urandom_range(0, 7)));
    end
    idle(4, 3'd0);
    chk("drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
